mips_16_run_monitor: RTL

//  Synthesizable run controller/monitor for the mips_16 core: resets the core, runs it for a bounded cycle

---
 rtl/mips_16_run_monitor_pkg.sv | 24 ++
 rtl/mips_16_wp_channel.sv | 32 +++
 rtl/mips_16_run_monitor.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mips_16_run_monitor_pkg.sv
// rtl/mips_16_run_monitor_pkg.sv - shared state and stop-cause definitions for the run monitor
package mips_16_run_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] STOP_NONE    = 2'd0;
  localparam logic [1:0] STOP_TIMEOUT = 2'd1;
  localparam logic [1:0] STOP_WP      = 2'd2;
  localparam logic [1:0] STOP_ABORT   = 2'd3;

  // Resolves simultaneous stop reasons: abort beats watchpoint beats timeout.
  function automatic logic [1:0] stop_code(input logic abort_req, input logic wp_req);
    if (abort_req)   return STOP_ABORT;
    else if (wp_req) return STOP_WP;
    else             return STOP_TIMEOUT;
  endfunction

endpackage

// File: rtl/mips_16_wp_channel.sv
// rtl/mips_16_wp_channel.sv - one PC watchpoint: comparator plus saturating hit counter
module mips_16_wp_channel #(
  parameter int PC_WIDTH = 8,
  parameter int HIT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                active,
  input  logic                changed,
  input  logic                en,
  input  logic [PC_WIDTH-1:0] wp_pc,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                hit,
  output logic [HIT_W-1:0]    hit_cnt
);

  // A PC parked on the watch address counts once, not once per stalled cycle.
  assign hit = active && en && changed && (pc == wp_pc);

  // Counter clears on an accepted start and sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt <= '0;
    end else if (clr) begin
      hit_cnt <= '0;
    end else if (hit && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mips_16_run_monitor.sv
// rtl/mips_16_run_monitor.sv - resets, runs, watches and snapshots the mips_16 core
module mips_16_run_monitor
  import mips_16_run_monitor_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int DATA_WIDTH = 16,
  parameter int REG_ADDR_W = 3,
  parameter int NUM_WP     = 2,
  parameter int CYC_W      = 16,
  parameter int HIT_W      = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [CYC_W-1:0]           max_cycles,
  input  logic [NUM_WP-1:0]          wp_en,
  input  logic [NUM_WP-1:0]          wp_stop,
  input  logic [NUM_WP*PC_WIDTH-1:0] wp_pc,
  input  logic [PC_WIDTH-1:0]        pc,
  output logic                       core_rst,
  output logic                       core_en,
  output logic [REG_ADDR_W-1:0]      rf_raddr,
  input  logic [DATA_WIDTH-1:0]      rf_rdata,
  input  logic [REG_ADDR_W-1:0]      snap_raddr,
  output logic [DATA_WIDTH-1:0]      snap_rdata,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 stop_cause,
  output logic [CYC_W-1:0]           cycle_cnt,
  output logic [NUM_WP*HIT_W-1:0]    hit_cnt
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam int RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

  state_t                     state;
  logic [RC_W-1:0]            rst_cnt;
  logic [CYC_W-1:0]           max_q;
  logic [NUM_WP-1:0]          wp_en_q;
  logic [NUM_WP-1:0]          wp_stop_q;
  logic [NUM_WP*PC_WIDTH-1:0] wp_pc_q;
  logic [PC_WIDTH-1:0]        pc_prev;
  logic                       pc_seen;
  logic [NUM_WP-1:0]          hit;
  logic [DATA_WIDTH-1:0]      snap [NUM_REGS];

  logic             start_ok;
  logic             in_run;
  logic             pc_changed;
  logic             wp_stop_hit;
  logic [CYC_W:0]   cyc_next;
  logic             timeout;
  logic             stop_now;

  assign start_ok    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign in_run      = (state == ST_RUN);
  assign pc_changed  = !pc_seen || (pc != pc_prev);
  assign wp_stop_hit = |(hit & wp_stop_q);
  // Compared one bit wider so a saturated counter never aliases onto a budget.
  assign cyc_next    = {1'b0, cycle_cnt} + {{CYC_W{1'b0}}, 1'b1};
  assign timeout     = (max_q != '0) && (cyc_next == {1'b0, max_q});
  assign stop_now    = in_run && (abort || wp_stop_hit || timeout);

  genvar k;
  generate
    for (k = 0; k < NUM_WP; k++) begin : g_wp
      mips_16_wp_channel #(
        .PC_WIDTH (PC_WIDTH),
        .HIT_W    (HIT_W)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .active  (in_run),
        .changed (pc_changed),
        .en      (wp_en_q[k]),
        .wp_pc   (wp_pc_q[k*PC_WIDTH +: PC_WIDTH]),
        .pc      (pc),
        .hit     (hit[k]),
        .hit_cnt (hit_cnt[k*HIT_W +: HIT_W])
      );
    end
  endgenerate

  // Run sequencer: owns core control, cycle budget, stop cause and the dump walk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      core_rst   <= 1'b1;
      core_en    <= 1'b0;
      rf_raddr   <= '0;
      cycle_cnt  <= '0;
      stop_cause <= STOP_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rst_cnt    <= '0;
      max_q      <= '0;
      wp_en_q    <= '0;
      wp_stop_q  <= '0;
      wp_pc_q    <= '0;
      pc_prev    <= '0;
      pc_seen    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            max_q      <= max_cycles;
            wp_en_q    <= wp_en;
            wp_stop_q  <= wp_stop;
            wp_pc_q    <= wp_pc;
            cycle_cnt  <= '0;
            stop_cause <= STOP_NONE;
            rst_cnt    <= '0;
            pc_seen    <= 1'b0;
            core_rst   <= 1'b1;
            core_en    <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            state      <= ST_RESET;
          end
        end
        ST_RESET: begin
          if (rst_cnt == RST_LAST) begin
            core_rst <= 1'b0;
            core_en  <= 1'b1;
            state    <= ST_RUN;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          pc_prev <= pc;
          pc_seen <= 1'b1;
          if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
          if (stop_now) begin
            stop_cause <= stop_code(abort, wp_stop_hit);
            core_en    <= 1'b0;
            rf_raddr   <= '0;
            state      <= ST_DUMP;
          end
        end
        ST_DUMP: begin
          if (rf_raddr == REG_ADDR_W'(NUM_REGS - 1)) begin
            rf_raddr <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            rf_raddr <= rf_raddr + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Snapshot buffer captures one register per dump clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        snap[i] <= '0;
      end
    end else if (state == ST_DUMP) begin
      snap[rf_raddr] <= rf_rdata;
    end
  end

  assign snap_rdata = snap[snap_raddr];

endmodule
